i2c_key_cmd: RTL and testbench

//  Upstream command source for the I2C control block. Synchronises and debounces
//  the raw active-low push keys. Emits one single-cycle command pulse per

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/key_debounce.sv | 57 +++++
 rtl/i2c_key_cmd.sv | 104 ++++++++++
 tb/tb_i2c_key_cmd.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//  Constants shared by the I2C control slice: number of command keys,
//  the bit position of each command inside a command word, the default
//  debounce length, and a helper that sizes a counter.
//  No ports.
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_NUM_CMD          = 3;
  localparam int CMD_START            = 0;
  localparam int CMD_XFER             = 1;
  localparam int CMD_STOP             = 2;
  localparam int I2C_DEBOUNCE_DEFAULT = 500000;

  // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//  One raw active-low key: synchroniser chain, stability counter and the
//  accepted (debounced) level, active-high.
//  Ports:
//   i_clk    system clock
//   i_reset  asynchronous active-high reset
//   i_key_n  raw key, active-low, asynchronous to i_clk
//   o_level  debounced level, 1 = pressed
// ---------------------------------------------------------------------------
module key_debounce
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = I2C_DEBOUNCE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_level
);

  localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_synced;

  // Chain resets to all-ones so a reset looks like "key released".
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_sync <= '1;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_n};
  end

  assign w_synced = ~r_sync[SYNC_STAGES-1];

  // Counter only runs while the synced input disagrees with the accepted
  // level; any agreeing cycle restarts the count, so short glitches vanish.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_synced == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_level <= ~r_level;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/i2c_key_cmd.sv
// ---------------------------------------------------------------------------
// i2c_key_cmd
//  Command source for the I2C control block. Debounces the push keys and
//  emits one single-cycle command per press-release gesture, carrying the
//  OR of every key held during the gesture. The command waits while the
//  downstream engine is busy.
//  Ports:
//   i_clk        system clock
//   i_reset      asynchronous active-high reset
//   i_key_n      raw keys, active-low, asynchronous
//   i_busy       downstream engine busy (1 = hold the command)
//   o_control    command pulse, high for exactly one cycle
//   o_pending    gesture complete, command waiting for i_busy=0
//   o_key_state  debounced key levels, 1 = pressed
// ---------------------------------------------------------------------------
module i2c_key_cmd
  import i2c_pkg::*;
#(
  parameter int NUM_KEYS        = I2C_NUM_CMD,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = I2C_DEBOUNCE_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NUM_KEYS-1:0] i_key_n,
  input  logic                i_busy,
  output logic [NUM_KEYS-1:0] o_control,
  output logic                o_pending,
  output logic [NUM_KEYS-1:0] o_key_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [NUM_KEYS-1:0] w_key_state;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_key_n (i_key_n[gi]),
      .o_level (w_key_state[gi])
    );
  end

  state_t              r_state,   w_state_nxt;
  logic [NUM_KEYS-1:0] r_mask,    w_mask_nxt;
  logic [NUM_KEYS-1:0] r_control, w_control_nxt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_control <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_control <= w_control_nxt;
    end
  end

  // Gesture = from first pressed key until all keys released. The mask
  // accumulates overlapping presses; WAIT ignores keys so nothing held
  // there can leak into the queued command.
  always_comb begin
    w_state_nxt   = r_state;
    w_mask_nxt    = r_mask;
    w_control_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_key_state) begin
          w_state_nxt = S_PRESS;
          w_mask_nxt  = w_key_state;
        end
      end
      S_PRESS: begin
        w_mask_nxt = r_mask | w_key_state;
        if (w_key_state == '0) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!i_busy) begin
          w_control_nxt = r_mask;
          w_mask_nxt    = '0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_mask_nxt  = '0;
      end
    endcase
  end

  assign o_control   = r_control;
  assign o_pending   = (r_state == S_WAIT);
  assign o_key_state = w_key_state;

endmodule

// File: tb/tb_i2c_key_cmd.sv
module tb_i2c_key_cmd;

  localparam int NK = 3;
  localparam int SS = 2;
  localparam int DC = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          busy  = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] control;
  logic          pending;
  logic [NK-1:0] key_state;

  i2c_key_cmd #(
    .NUM_KEYS        (NK),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_key_n     (key_n),
    .i_busy      (busy),
    .o_control   (control),
    .o_pending   (pending),
    .o_key_state (key_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NK-1:0] ctrl;
    int            at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   prev_nz = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every nonzero control is matched against the oldest
  // expected command; a pulse with nothing queued is an error.
  always @(negedge clk) begin
    if (mon_en) begin
      if (control !== '0) begin
        chk("pulse_width", 32'(prev_nz), 0);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'(control), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("ctrl_val", 32'(control), 32'(mon_e.ctrl));
          if (mon_e.at >= 0) chk("ctrl_time", cyc, mon_e.at);
        end
        prev_nz = 1'b1;
      end else begin
        prev_nz = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NK-1:0] ks_or;
    int            cnt;
    int            w;

    // 1: reset mid-clock, outputs clear at once and stay clear
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_control",   32'(control),   0);
    chk("rst_pending",   32'(pending),   0);
    chk("rst_key_state", 32'(key_state), 0);
    mon_en = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("post_rst_control",   32'(control),   0);
    chk("post_rst_pending",   32'(pending),   0);
    chk("post_rst_key_state", 32'(key_state), 0);

    // 2: 3-cycle glitch is rejected
    key_n[0] = 1'b0;
    tick(3);
    key_n[0] = 1'b1;
    ks_or = '0;
    repeat (12) begin
      @(negedge clk);
      ks_or |= key_state;
    end
    chk("glitch_ks", 32'(ks_or), 0);
    tick(1);

    // 3: single key, exact latency from the raw release edge
    key_n[0] = 1'b0;
    tick(10);
    chk("t3_press_ks", 32'(key_state), 32'b001);
    key_n[0] = 1'b1;
    sb.push_back('{3'b001, cyc + SS + DC + 2});
    tick(7);
    chk("t3_release_ks", 32'(key_state), 0);
    tick(5);
    chk("t3_drain", sb.size(), 0);

    // 4: overlapping key0/key2 merge into one command
    key_n[0] = 1'b0;
    tick(5);
    key_n[2] = 1'b0;
    tick(7);
    key_n[0] = 1'b1;
    tick(8);
    chk("t4_ks_key2_only", 32'(key_state), 32'b100);
    key_n[2] = 1'b1;
    sb.push_back('{3'b101, cyc + SS + DC + 2});
    tick(14);
    chk("t4_drain", sb.size(), 0);

    // 5: busy holds the command, release on busy drop
    busy = 1'b1;
    key_n[1] = 1'b0;
    tick(10);
    key_n[1] = 1'b1;
    tick(8);
    chk("t5_pending", 32'(pending), 1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (pending === 1'b1 && control === '0) cnt++;
    end
    chk("t5_hold", cnt, 20);
    @(posedge clk);
    #1;
    busy = 1'b0;
    sb.push_back('{3'b010, cyc + 1});
    @(posedge clk);
    @(negedge clk);
    chk("t5_pend_fall", 32'(pending), 0);
    tick(3);
    chk("t5_drain", sb.size(), 0);

    // 6: reset during PRESS cancels the gesture
    key_n[0] = 1'b0;
    w = 0;
    while (key_state[0] !== 1'b1 && w < 20) begin
      tick(1);
      w++;
    end
    chk("t6_press_ks", 32'(key_state[0]), 1);
    tick(2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_ks",      32'(key_state), 0);
    chk("t6_rst_pending", 32'(pending),   0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);
    key_n[0] = 1'b1;
    tick(15);
    chk("t6_no_pulse", sb.size(), 0);
    key_n[0] = 1'b0;
    tick(10);
    key_n[0] = 1'b1;
    sb.push_back('{3'b001, cyc + SS + DC + 2});
    tick(14);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
